// File: rtl/cnt_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
//   Shared definitions for the up/down modulo-N counter family.
//
//   Contents:
//     CNT_UP / CNT_DN  - encoding of the up_dn direction input
//     cnt_flags_t      - registered status bits kept next to the count
//     cnt_clog2()      - constant function used for elaboration-time
//                        width checks (ceil(log2(value)), 0 for value <= 1)
//
//   Configuration: none here. The saturating-mode macro COUNTER_SAT_EN is
//   consumed by cnt_next_val.
// -----------------------------------------------------------------------------
package cnt_pkg;

   // Direction encoding for up_dn.
   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   // Status registers that travel together with the count value.
   //   wrap - one-cycle pulse following a wrap (or a blocked step in
   //          saturating mode)
   //   ovf  - sticky, an up-step was attempted at MODULUS-1
   //   unf  - sticky, a down-step was attempted at 0
   typedef struct packed {
      logic wrap;
      logic ovf;
      logic unf;
   } cnt_flags_t;

   // Number of bits needed to represent value-1, i.e. ceil(log2(value)).
   // Bounded loop so it stays usable as a constant function everywhere.
   function automatic int cnt_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if (value > (1 << i)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/cnt_next_val.sv
// -----------------------------------------------------------------------------
// cnt_next_val
//   Combinational next-count and terminal-count logic for the up/down
//   modulo-N counter. No state.
//
//   Parameters:
//     WIDTH    - count width in bits
//     MODULUS  - count range is 0..MODULUS-1
//
//   Ports:
//     q        in   WIDTH  current count
//     up_dn    in   1      CNT_UP = count up, CNT_DN = count down
//     en       in   1      step request
//     nxt      out  WIDTH  value the count takes if this step is applied
//                          (equals q when en is low)
//     at_term  out  1      en is high and q sits on the terminal value for
//                          the current direction (MODULUS-1 up, 0 down)
//
//   Configuration:
//     COUNTER_SAT_EN defined   - at the terminal value the count holds
//     COUNTER_SAT_EN undefined - at the terminal value the count wraps
// -----------------------------------------------------------------------------
module cnt_next_val
   import cnt_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up_dn,
   input  logic             en,
   output logic [WIDTH-1:0] nxt,
   output logic             at_term
);

   // One extra bit so MODULUS == 2**WIDTH and the down-step borrow are both
   // representable without aliasing.
   localparam logic [WIDTH:0]   TERM_HI_EXT = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0]   ONE_EXT     = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   NEG_ONE_EXT = '1;
   localparam logic [WIDTH-1:0] TERM_HI_Q   = WIDTH'(MODULUS - 1);

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] step_ext;
   logic           at_hi;
   logic           at_lo;
   logic           on_term;

   assign q_ext = {1'b0, q};

   // Single adder serves both directions: +1 or +(-1) in WIDTH+1 bits.
   assign step_ext = q_ext + ((up_dn == CNT_UP) ? ONE_EXT : NEG_ONE_EXT);

   // Upper terminal is compared against MODULUS-1, never the all-ones value,
   // so a non-power-of-2 modulus wraps at the right place.
   assign at_hi = (q_ext == TERM_HI_EXT);

   // Counting down, q-1 borrows into the extra bit exactly when q == 0.
   // Only consulted while counting down.
   assign at_lo = step_ext[WIDTH];

   assign on_term = (up_dn == CNT_UP) ? at_hi : at_lo;
   assign at_term = en & on_term;

   always_comb begin
      nxt = q;
      if (en) begin
         if (on_term) begin
`ifdef COUNTER_SAT_EN
            nxt = q;
`else
            nxt = (up_dn == CNT_UP) ? '0 : TERM_HI_Q;
`endif
         end else begin
            nxt = step_ext[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//   Synchronous up/down modulo-N counter with direction control, synchronous
//   clear/load, terminal-count and wrap outputs, and sticky overflow and
//   underflow flags. Single clock domain; used as a timebase / event counter.
//
//   Parameters:
//     WIDTH    (3)  count width in bits, >= 1
//     MODULUS  (8)  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//     RST_VAL  (0)  value taken on rst and clr, < MODULUS
//
//   Ports:
//     clk         in   1      clock, rising edge
//     rst         in   1      asynchronous reset, active high
//     en          in   1      count enable, one step per clock
//     up_dn       in   1      1 = up, 0 = down, sampled every cycle
//     clr         in   1      synchronous clear to RST_VAL (highest priority)
//     load        in   1      synchronous load of load_val (clamped)
//     load_val    in   WIDTH  value for load
//     sticky_clr  in   1      clears ovf/unf; a same-cycle new event wins
//     q           out  WIDTH  registered count
//     tc          out  1      combinational terminal count for the current
//                             direction, qualified by en
//     wrap        out  1      registered pulse the cycle after a wrap, or
//                             after a blocked step in saturating mode
//     ovf         out  1      sticky: up-step attempted at MODULUS-1
//     unf         out  1      sticky: down-step attempted at 0
//
//   Handshake: none; every input is sampled on each rising clk edge.
//   Priority each cycle: clr > load > en.
//
//   Configuration:
//     COUNTER_SAT_EN defined   - saturate at the terminal values
//     COUNTER_SAT_EN undefined - wrap around (default)
// -----------------------------------------------------------------------------
module updown_mod_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sticky_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             unf
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (WIDTH < 1) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be >= 1");
   end
   if (MODULUS < 2) begin : g_bad_mod_lo
      $error("updown_mod_counter: MODULUS must be >= 2");
   end
   if (cnt_clog2(MODULUS) > WIDTH) begin : g_bad_mod_hi
      $error("updown_mod_counter: MODULUS must be <= 2**WIDTH");
   end
   if ((RST_VAL < 0) || (RST_VAL >= MODULUS)) begin : g_bad_rst_val
      $error("updown_mod_counter: RST_VAL must be in 0..MODULUS-1");
   end

   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   cnt_flags_t       flags_q;
   cnt_flags_t       flags_d;

   // ---------------------------------------------------------------------------
   // Next-value / terminal logic
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] nxt;
   logic             at_term;

   cnt_next_val #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .q       (q_q),
      .up_dn   (up_dn),
      .en      (en),
      .nxt     (nxt),
      .at_term (at_term)
   );

   // Out-of-range load values clamp to the top of the range so q never
   // leaves 0..MODULUS-1. Compare is done in WIDTH+1 bits because MODULUS
   // itself may be 2**WIDTH.
   logic [WIDTH-1:0] load_clamped;
   assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_Q : load_val;

   // ---------------------------------------------------------------------------
   // Priority mux and flag update
   // ---------------------------------------------------------------------------
   always_comb begin
      q_d          = q_q;
      flags_d.wrap = 1'b0;
      // Clear first, then OR in a new event so a same-cycle event wins.
      flags_d.ovf  = flags_q.ovf & ~sticky_clr;
      flags_d.unf  = flags_q.unf & ~sticky_clr;

      if (clr) begin
         q_d = RST_Q;
      end else if (load) begin
         q_d = load_clamped;
      end else if (en) begin
         q_d = nxt;
         if (at_term) begin
            flags_d.wrap = 1'b1;
            if (up_dn == CNT_UP) begin
               flags_d.ovf = 1'b1;
            end else begin
               flags_d.unf = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q     <= RST_Q;
         flags_q <= '0;
      end else begin
         q_q     <= q_d;
         flags_q <= flags_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign q    = q_q;
   assign tc   = at_term;
   assign wrap = flags_q.wrap;
   assign ovf  = flags_q.ovf;
   assign unf  = flags_q.unf;

endmodule

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
//   Two counter instances share one set of inputs: a power-of-2 modulus
//   (WIDTH=3, MODULUS=8, RST_VAL=0) and a non-power-of-2 modulus
//   (WIDTH=3, MODULUS=6, RST_VAL=2). A modulo-arithmetic reference model
//   predicts both. Honors COUNTER_SAT_EN when defined.
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;

   localparam int W = 3;

`ifdef COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         up_dn = 1'b1;
   logic         clr = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         sticky_clr = 1'b0;

   logic [W-1:0] q8, q6;
   logic         tc8, tc6, wrap8, wrap6, ovf8, ovf6, unf8, unf6;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(3), .MODULUS(8), .RST_VAL(0)) dut8 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .sticky_clr(sticky_clr),
      .q(q8), .tc(tc8), .wrap(wrap8), .ovf(ovf8), .unf(unf8)
   );

   updown_mod_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(2)) dut6 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .sticky_clr(sticky_clr),
      .q(q6), .tc(tc6), .wrap(wrap6), .ovf(ovf6), .unf(unf6)
   );

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------------
   int           mod_a[2] = '{8, 6};
   int           rv_a[2]  = '{0, 2};
   int           m_q[2];
   bit           m_wrap[2];
   bit           m_ovf[2];
   bit           m_unf[2];
   logic [W-1:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] a_q(input int i);
      return (i == 0) ? 32'(q8) : 32'(q6);
   endfunction
   function automatic logic [31:0] a_tc(input int i);
      return (i == 0) ? 32'(tc8) : 32'(tc6);
   endfunction
   function automatic logic [31:0] a_wrap(input int i);
      return (i == 0) ? 32'(wrap8) : 32'(wrap6);
   endfunction
   function automatic logic [31:0] a_ovf(input int i);
      return (i == 0) ? 32'(ovf8) : 32'(ovf6);
   endfunction
   function automatic logic [31:0] a_unf(input int i);
      return (i == 0) ? 32'(unf8) : 32'(unf6);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         m_q[i]    = rv_a[i];
         m_wrap[i] = 1'b0;
         m_ovf[i]  = 1'b0;
         m_unf[i]  = 1'b0;
         exp_q.push_back(W'(m_q[i]));
      end
   endtask

   // One rising edge of the specified behaviour, using the current inputs.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int m;
         bit at_end;
         m = mod_a[i];
         m_wrap[i] = 1'b0;
         if (sticky_clr) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
         end
         if (clr) begin
            m_q[i] = rv_a[i];
         end else if (load) begin
            m_q[i] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
         end else if (en) begin
            at_end = up_dn ? (m_q[i] == m - 1) : (m_q[i] == 0);
            if (at_end) begin
               m_wrap[i] = 1'b1;
               if (up_dn) m_ovf[i] = 1'b1;
               else       m_unf[i] = 1'b1;
            end
            if (!(SAT && at_end)) begin
               m_q[i] = up_dn ? (m_q[i] + 1) % m : (m_q[i] + m - 1) % m;
            end
         end
         exp_q.push_back(W'(m_q[i]));
      end
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         logic [W-1:0] e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected-queue empty, got q %0d", tag, a_q(i));
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s q[m%0d]", tag, mod_a[i]), a_q(i), int'(e));
         end
         chk($sformatf("%s wrap[m%0d]", tag, mod_a[i]), a_wrap(i), int'(m_wrap[i]));
         chk($sformatf("%s ovf[m%0d]", tag, mod_a[i]), a_ovf(i), int'(m_ovf[i]));
         chk($sformatf("%s unf[m%0d]", tag, mod_a[i]), a_unf(i), int'(m_unf[i]));
         chk($sformatf("%s range[m%0d]", tag, mod_a[i]), 32'(a_q(i) < 32'(mod_a[i])), 1);
      end
   endtask

   task automatic check_tc(input string tag);
      for (int i = 0; i < 2; i++) begin
         bit e;
         e = en && (up_dn ? (m_q[i] == mod_a[i] - 1) : (m_q[i] == 0));
         chk($sformatf("%s tc[m%0d]", tag, mod_a[i]), a_tc(i), int'(e));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks (called at the falling edge)
   // ---------------------------------------------------------------------------
   task automatic drive(input logic e, input logic u, input logic c,
                        input logic l, input logic [W-1:0] lv, input logic s);
      en = e; up_dn = u; clr = c; load = l; load_val = lv; sticky_clr = s;
   endtask

   task automatic tick(input string tag);
      #1;
      check_tc(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_state(tag);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   typedef struct {
      logic         en;
      logic         up;
      logic         clr;
      logic         ld;
      logic [W-1:0] lv;
      logic         sc;
      int           e_q;
      bit           e_tc;
      bit           e_wrap;
      bit           e_ovf;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int wraps;
      int e6_wrap[8] = '{5, 4, 3, 2, 1, 0, 5, 4};
      int e8_t5_wrap[4] = '{7, 0, 1, 2};

      // Test 1 table: MODULUS=8 counting up from reset for 10 clocks.
      for (int k = 0; k < 10; k++) begin
         tbl[k].en = 1'b1; tbl[k].up = 1'b1; tbl[k].clr = 1'b0;
         tbl[k].ld = 1'b0; tbl[k].lv = '0;   tbl[k].sc = 1'b0;
         tbl[k].e_q    = SAT ? ((k < 7) ? k + 1 : 7) : (k + 1) % 8;
         tbl[k].e_tc   = SAT ? (k >= 7) : (k == 7);
         tbl[k].e_wrap = SAT ? (k >= 7) : (k == 7);
         tbl[k].e_ovf  = (k >= 7);
      end

      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      check_state("reset");
      check_tc("reset");
      rst = 1'b0;

      // Test 1: table-driven up count
      for (int k = 0; k < 10; k++) begin
         drive(tbl[k].en, tbl[k].up, tbl[k].clr, tbl[k].ld, tbl[k].lv, tbl[k].sc);
         #1;
         chk($sformatf("t1[%0d] tc8", k), 32'(tc8), int'(tbl[k].e_tc));
         tick($sformatf("t1[%0d]", k));
         chk($sformatf("t1[%0d] q8", k), 32'(q8), tbl[k].e_q);
         chk($sformatf("t1[%0d] wrap8", k), 32'(wrap8), int'(tbl[k].e_wrap));
         chk($sformatf("t1[%0d] ovf8", k), 32'(ovf8), int'(tbl[k].e_ovf));
      end

      // Test 2: MODULUS=6 counting down from 0
      drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      tick("t2 load0");
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
         tick($sformatf("t2[%0d]", k));
         chk($sformatf("t2[%0d] q6", k), 32'(q6), SAT ? 0 : e6_wrap[k]);
         if (k == 0) chk("t2 unf6 first", 32'(unf6), 1);
      end

      // Test 3: load clamp and clr-over-load priority
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
      tick("t3 load7");
      chk("t3 load7 q6", 32'(q6), 5);
      chk("t3 load7 q8", 32'(q8), 7);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0);
      tick("t3 clr+load");
      chk("t3 clr+load q8", 32'(q8), 0);
      chk("t3 clr+load q6", 32'(q6), 2);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
      tick("t3 load6");
      chk("t3 load6 q6", 32'(q6), 5);
      chk("t3 load6 q8", 32'(q8), 6);

      // Test 4: asynchronous reset between edges at q8=3
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
      tick("t4 load0");
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
         tick($sformatf("t4 up[%0d]", k));
      end
      chk("t4 pre q8", 32'(q8), 3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_state("t4 async");
      chk("t4 async q8", 32'(q8), 0);
      chk("t4 async ovf8", 32'(ovf8), 0);
      rst = 1'b0;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_state("t4 resume");
      chk("t4 resume q8", 32'(q8), 1);

      // Test 5: from q=6 (MODULUS=8) up for 4 clocks
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1);
      tick("t5 load6");
      wraps = 0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
         tick($sformatf("t5[%0d]", k));
         chk($sformatf("t5[%0d] q8", k), 32'(q8), SAT ? 7 : e8_t5_wrap[k]);
         if (wrap8 === 1'b1) wraps++;
      end
      chk("t5 wrap8 pulses", 32'(wraps), SAT ? 3 : 1);
      chk("t5 ovf8", 32'(ovf8), 1);

      // Test 6: sticky clear alone, and together with a new overflow
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      tick("t6 sc alone a");
      chk("t6 sc alone a ovf8", 32'(ovf8), 0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
      tick("t6 load7");
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      tick("t6 sc+ovf");
      chk("t6 sc+ovf ovf8", 32'(ovf8), 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      tick("t6 sc alone b");
      chk("t6 sc alone b ovf8", 32'(ovf8), 0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(logic'($urandom_range(0, 3) != 0),
               logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 15) == 0),
               logic'($urandom_range(0, 15) == 0),
               W'($urandom_range(0, 7)),
               logic'($urandom_range(0, 15) == 0));
         tick($sformatf("rnd[%0d]", n));
      end

      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
